// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmit and keyboard receive paths.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        SHIFT,
        ACK,
        WAIT_IDLE
    } ps2_state_e;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_ECHO    = 8'hEE;
    localparam logic [7:0] ACK_BYTE    = 8'hFA;

    localparam int CNT_W = 16;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one PS/2 pad plus a falling-edge pulse on the synced level.
module ps2_sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pad,
    output logic o_level,
    output logic o_fe
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = i_pad;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Reset to the idle-high bus level so leaving reset never fakes an edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign o_level = sync_q;
    assign o_fe    = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, start bit, 8 data + odd parity + stop,
// device acknowledge, bus-idle wait, with a watchdog on the device clock.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC = 1300,
    parameter int START_CYC   = 24,
    parameter int TIMEOUT_CYC = 24000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_dat_oe,
    output logic       o_done,
    output logic       o_ack_ok,
    output logic       o_timeout,
    output logic       o_busy
);
    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYC - 1);
    localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    ps2_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic [8:0]       frame_q, frame_d;
    logic             clk_oe_q, clk_oe_d;
    logic             dat_oe_q, dat_oe_d;
    logic             done_q, done_d;
    logic             ack_ok_q, ack_ok_d;
    logic             timeout_q, timeout_d;
    logic             idle_cnt_q, idle_cnt_d;

    logic clk_level, clk_fe, dat_level, dat_fe_unused;

    ps2_sync_edge u_clk_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_pad  (i_ps2_clk),
        .o_level(clk_level),
        .o_fe   (clk_fe)
    );

    ps2_sync_edge u_dat_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_pad  (i_ps2_dat),
        .o_level(dat_level),
        .o_fe   (dat_fe_unused)
    );

    // Handshake: a byte is taken in any cycle with i_valid && o_ready; o_ready stays low
    // through the o_done cycle, so a request is never queued or taken while busy.
    assign o_ready = (state_q == IDLE) && !done_q;
    assign o_busy  = ~o_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        frame_d    = frame_q;
        clk_oe_d   = clk_oe_q;
        dat_oe_d   = dat_oe_q;
        done_d     = 1'b0;
        ack_ok_d   = ack_ok_q;
        timeout_d  = timeout_q;
        idle_cnt_d = idle_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (i_valid && o_ready) begin
                    frame_d   = {odd_parity(i_data), i_data};
                    ack_ok_d  = 1'b0;
                    timeout_d = 1'b0;
                    cnt_d     = '0;
                    clk_oe_d  = 1'b1;
                    dat_oe_d  = 1'b0;
                    state_d   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt_q == INHIBIT_LAST) begin
                    cnt_d    = '0;
                    dat_oe_d = 1'b1;
                    state_d  = START;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            START: begin
                if (cnt_q == START_LAST) begin
                    cnt_d     = '0;
                    clk_oe_d  = 1'b0;
                    bit_idx_d = '0;
                    state_d   = SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT, ACK, WAIT_IDLE: begin
                // A device clock edge outranks a watchdog expiry landing in the same cycle.
                if (clk_fe) begin
                    cnt_d      = '0;
                    idle_cnt_d = 1'b0;
                    if (state_q == SHIFT) begin
                        if (bit_idx_q == 4'd9) begin
                            dat_oe_d = 1'b0;
                            state_d  = ACK;
                        end else begin
                            dat_oe_d  = ~frame_q[bit_idx_q];
                            bit_idx_d = bit_idx_q + 1'b1;
                        end
                    end else if (state_q == ACK) begin
                        ack_ok_d = ~dat_level;
                        state_d  = WAIT_IDLE;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d     = '0;
                    clk_oe_d  = 1'b0;
                    dat_oe_d  = 1'b0;
                    done_d    = 1'b1;
                    ack_ok_d  = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (state_q == WAIT_IDLE) begin
                        if (clk_level && dat_level) begin
                            idle_cnt_d = 1'b1;
                            if (idle_cnt_q) begin
                                cnt_d      = '0;
                                idle_cnt_d = 1'b0;
                                done_d     = 1'b1;
                                timeout_d  = 1'b0;
                                state_d    = IDLE;
                            end
                        end else begin
                            idle_cnt_d = 1'b0;
                        end
                    end
                end
            end
            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                cnt_d    = '0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            frame_q    <= '0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            done_q     <= 1'b0;
            ack_ok_q   <= 1'b0;
            timeout_q  <= 1'b0;
            idle_cnt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            frame_q    <= frame_d;
            clk_oe_q   <= clk_oe_d;
            dat_oe_q   <= dat_oe_d;
            done_q     <= done_d;
            ack_ok_q   <= ack_ok_d;
            timeout_q  <= timeout_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign o_ps2_clk_oe = clk_oe_q;
    assign o_ps2_dat_oe = dat_oe_q;
    assign o_done       = done_q;
    assign o_ack_ok     = ack_ok_q;
    assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain bus with a behavioural keyboard that clocks the frame
// in, samples on rising clock, and optionally acknowledges.
module tb_ps2_host_tx;
    localparam int INHIBIT  = 1300;
    localparam int START    = 24;
    localparam int TIMEOUT  = 24000;
    localparam int SYNC_LAT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic       ready, busy, clk_oe, dat_oe, done, ack_ok, timeout;
    logic       dev_clk, dev_dat;
    logic       clk_line, dat_line;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic done_ack, done_to, done_rdy;

    logic [9:0] exp_q[$];

    assign clk_line = dev_clk & ~clk_oe;
    assign dat_line = dev_dat & ~dat_oe;

    ps2_host_tx dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_ps2_clk   (clk_line),
        .i_ps2_dat   (dat_line),
        .i_valid     (valid),
        .i_data      (data),
        .o_ready     (ready),
        .o_ps2_clk_oe(clk_oe),
        .o_ps2_dat_oe(dat_oe),
        .o_done      (done),
        .o_ack_ok    (ack_ok),
        .o_timeout   (timeout),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_ack <= ack_ok;
            done_to  <= timeout;
            done_rdy <= ready;
            done_cyc <= cyc;
        end
    end

    initial begin
        #(150000 * 10);
        $display("FAIL watchdog: simulation did not finish within 150000 cycles");
        $fatal(1, "watchdog");
    end

    // Reference frame as the device should see it: data LSB first, odd parity, stop=1.
    function automatic logic [9:0] model_frame(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, (ones % 2 == 0), d};
    endfunction

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        valid = 1'b1;
        data  = d;
        @(negedge clk);
        valid = 1'b0;
        exp_q.push_back(model_frame(d));
    endtask

    task automatic dev_xfer(input int half, input bit ack, input int nclk,
                            output logic [9:0] bits, output int inh, output int inh_dat,
                            output bit start_ok, output int last_fall);
        bits = '0;
        inh = 0;
        inh_dat = 0;
        last_fall = 0;
        while (clk_oe && inh < 5000) begin
            inh++;
            if (!dat_oe) inh_dat++;
            @(negedge clk);
        end
        start_ok = (dat_line == 1'b0);
        for (int k = 1; k <= nclk; k++) begin
            if (k == 11) dev_dat = ~ack;
            repeat (half) @(negedge clk);
            dev_clk = 1'b0;
            last_fall = cyc;
            repeat (half) @(negedge clk);
            if (k <= 10) bits[k-1] = dat_line;
            dev_clk = 1'b1;
            if (k == 11) dev_dat = 1'b1;
        end
    endtask

    task automatic wait_done(input int prev, input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt > prev) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks += 4;
        if (ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_ready: ready=%b busy=%b expected 1/0", ready, busy);
        end
        if (clk_oe !== 1'b0 || dat_oe !== 1'b0) begin
            errors++; $display("FAIL reset_oe: clk_oe=%b dat_oe=%b expected 0/0", clk_oe, dat_oe);
        end
        if (done !== 1'b0) begin
            errors++; $display("FAIL reset_done: got %b expected 0", done);
        end
        if (ack_ok !== 1'b0 || timeout !== 1'b0) begin
            errors++; $display("FAIL reset_status: ack=%b to=%b expected 0/0", ack_ok, timeout);
        end
        rst = 1'b0;
    endtask

    task automatic test_set_led();
        logic [9:0] bits, exp;
        int inh, inh_dat, lf, prev;
        bit st, got;
        prev = done_cnt;
        send(ps2_pkg::CMD_SET_LED);
        dev_xfer(500, 1'b1, 11, bits, inh, inh_dat, st, lf);
        wait_done(prev, 2000, got);
        exp = exp_q.pop_front();
        checks += 7;
        if (inh !== INHIBIT + START) begin
            errors++; $display("FAIL led_clk_low: got %0d cycles expected %0d", inh, INHIBIT + START);
        end
        if (inh_dat !== INHIBIT) begin
            errors++; $display("FAIL led_inhibit: got %0d cycles expected %0d", inh_dat, INHIBIT);
        end
        if (st !== 1'b1) begin
            errors++; $display("FAIL led_start_bit: data line not low at clock release");
        end
        if (bits !== exp) begin
            errors++; $display("FAIL led_bits: got %b expected %b", bits, exp);
        end
        if (!got || done_ack !== 1'b1 || done_to !== 1'b0) begin
            errors++; $display("FAIL led_done: got=%b ack=%b to=%b expected 1/1/0", got, done_ack, done_to);
        end
        if (done_rdy !== 1'b0) begin
            errors++; $display("FAIL led_ready_at_done: got %b expected 0", done_rdy);
        end
        @(negedge clk);
        if (clk_oe !== 1'b0 || dat_oe !== 1'b0 || ready !== 1'b1) begin
            errors++; $display("FAIL led_after: clk_oe=%b dat_oe=%b ready=%b expected 0/0/1", clk_oe, dat_oe, ready);
        end
    endtask

    task automatic run_full(input string name, input logic [7:0] d, input int half, input bit ack);
        logic [9:0] bits, exp;
        int inh, inh_dat, lf, prev;
        bit st, got;
        prev = done_cnt;
        send(d);
        dev_xfer(half, ack, 11, bits, inh, inh_dat, st, lf);
        wait_done(prev, 2000, got);
        exp = exp_q.pop_front();
        checks += 2;
        if (bits !== exp) begin
            errors++; $display("FAIL %s_bits: data %h got %b expected %b", name, d, bits, exp);
        end
        if (!got || done_ack !== ack || done_to !== 1'b0) begin
            errors++; $display("FAIL %s_done: got=%b ack=%b to=%b expected 1/%b/0", name, got, done_ack, done_to, ack);
        end
    endtask

    task automatic test_parity();
        run_full("par07", 8'h07, $urandom_range(40, 120), 1'b1);
        run_full("par00", 8'h00, $urandom_range(40, 120), 1'b1);
    endtask

    task automatic test_nack();
        run_full("nack", ps2_pkg::CMD_RESET, $urandom_range(40, 120), 1'b0);
    endtask

    task automatic test_timeout();
        logic [9:0] bits, exp;
        int inh, inh_dat, lf, prev;
        bit st, got;
        prev = done_cnt;
        send(ps2_pkg::CMD_SET_LED);
        dev_xfer(100, 1'b1, 4, bits, inh, inh_dat, st, lf);
        wait_done(prev, TIMEOUT + 500, got);
        exp = exp_q.pop_front();
        checks += 4;
        if (bits[3:0] !== exp[3:0]) begin
            errors++; $display("FAIL to_bits: got %b expected %b", bits[3:0], exp[3:0]);
        end
        if (!got || done_to !== 1'b1 || done_ack !== 1'b0) begin
            errors++; $display("FAIL to_done: got=%b to=%b ack=%b expected 1/1/0", got, done_to, done_ack);
        end
        if (done_cyc - lf !== TIMEOUT + SYNC_LAT) begin
            errors++; $display("FAIL to_latency: got %0d cycles from pad edge expected %0d", done_cyc - lf, TIMEOUT + SYNC_LAT);
        end
        if (clk_oe !== 1'b0 || dat_oe !== 1'b0) begin
            errors++; $display("FAIL to_oe: clk_oe=%b dat_oe=%b expected 0/0", clk_oe, dat_oe);
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] bits, exp;
        int inh, inh_dat, lf, prev;
        bit st;
        prev = done_cnt;
        send(8'($urandom_range(0, 255)));
        dev_xfer(60, 1'b1, 6, bits, inh, inh_dat, st, lf);
        exp = exp_q.pop_front();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks += 4;
        if (clk_oe !== 1'b0 || dat_oe !== 1'b0) begin
            errors++; $display("FAIL rst_mid_oe: clk_oe=%b dat_oe=%b expected 0/0", clk_oe, dat_oe);
        end
        if (ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_ready: got %b expected 1", ready);
        end
        if (bits[5:0] !== exp[5:0]) begin
            errors++; $display("FAIL rst_mid_bits: got %b expected %b", bits[5:0], exp[5:0]);
        end
        rst = 1'b0;
        repeat (100) @(negedge clk);
        if (done_cnt !== prev) begin
            errors++; $display("FAIL rst_mid_no_done: got %0d done pulses expected 0", done_cnt - prev);
        end
        run_full("echo", ps2_pkg::CMD_ECHO, 70, 1'b1);
    endtask

    task automatic test_busy_ignore();
        logic [9:0] bits, exp;
        logic [7:0] d1;
        int inh, inh_dat, lf, prev, half;
        bit st, got;
        d1 = 8'($urandom_range(0, 255));
        half = 60;
        prev = done_cnt;
        send(d1);
        fork
            dev_xfer(half, 1'b1, 11, bits, inh, inh_dat, st, lf);
            begin
                repeat (INHIBIT + START + 6 * half) @(negedge clk);
                valid = 1'b1;
                data  = ~d1;
                @(negedge clk);
                valid = 1'b0;
            end
        join
        wait_done(prev, 2000, got);
        repeat (300) @(negedge clk);
        exp = exp_q.pop_front();
        checks += 3;
        if (done_cnt - prev !== 1) begin
            errors++; $display("FAIL busy_done_count: got %0d expected 1", done_cnt - prev);
        end
        if (bits !== exp) begin
            errors++; $display("FAIL busy_bits: got %b expected %b", bits, exp);
        end
        if (clk_oe !== 1'b0 || ready !== 1'b1) begin
            errors++; $display("FAIL busy_after: clk_oe=%b ready=%b expected 0/1", clk_oe, ready);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3; n++) begin
            run_full("rand", 8'($urandom_range(0, 255)), $urandom_range(30, 80), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        rst = 1'b1;
        valid = 1'b0;
        data = 8'h00;
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        test_reset();
        repeat (5) @(negedge clk);
        test_set_led();
        test_parity();
        test_nack();
        test_timeout();
        test_reset_mid();
        test_busy_ignore();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter that sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard on PS2_CLK/PS2_DAT.
- Complements the existing device-to-host keyboard receive path inside Top; runs on CLK_12M.
- Drives the bus open-drain via output-enable bits. The top level ties each line to 0 when its enable is set and 'z otherwise.
- Reports per-byte completion, acknowledge and timeout status to the command issuer.

Parameters:
- INHIBIT_CYC, 1300: cycles the host holds the clock low before the start bit (≥100 µs at 12 MHz).
- START_CYC, 24: cycles data is held low, with clock still low, before the clock is released.
- TIMEOUT_CYC, 24000: maximum cycles between device clock falling edges (2 ms) before the transfer aborts.

Ports:
- i_clk  in  1  system clock (CLK_12M)
- i_rst  in  1  synchronous, active-high reset
- i_ps2_clk  in  1  raw PS2_CLK pad level (asynchronous)
- i_ps2_dat  in  1  raw PS2_DAT pad level (asynchronous)
- i_valid  in  1  request to send i_data; accepted only while o_ready=1
- i_data  in  8  command byte
- o_ready  out  1  idle, can accept a byte
- o_ps2_clk_oe  out  1  1 = pull PS2_CLK low
- o_ps2_dat_oe  out  1  1 = pull PS2_DAT low
- o_done  out  1  one-cycle pulse at the end of every transfer
- o_ack_ok  out  1  valid with o_done: device acknowledged the byte
- o_timeout  out  1  valid with o_done: transfer aborted on timeout
- o_busy  out  1  inverse of o_ready

Behaviour:
- Clock and reset: one clock. Reset is synchronous, active-high, on i_rst.
- Reset values: o_ready=1, o_busy=0, both OE=0, o_done=0, o_ack_ok=0, o_timeout=0, state IDLE, all counters 0.
- Reset mid-transfer releases both lines on the next edge. No o_done is generated.
- Input conditioning: i_ps2_clk and i_ps2_dat pass through a 2-FF synchronizer. A falling edge (fe) is a synchronized 1→0 transition: one-cycle pulse, 3-cycle latency from the pad.
- Frame: {odd_parity, i_data} is latched in the cycle i_valid && o_ready. Odd parity = ~^i_data.
- IDLE: o_ready=1. On accept, go to INHIBIT. A request while busy is ignored, not queued.
- INHIBIT: clk_oe=1, dat_oe=0, count INHIBIT_CYC cycles, then go to START.
- START: clk_oe=1, dat_oe=1 (start bit 0), count START_CYC cycles, then go to SHIFT with clk_oe=0 and bit index 0.
- SHIFT (on each fe, bit index 0..9 indexes the latched frame):
  - index 0..7: data bits, LSB first; dat_oe = ~bit.
  - index 8: parity bit; dat_oe = ~parity.
  - index 9: stop bit; dat_oe = 0 (line released).
  - The data line keeps its previous value until the fe. The 10th fe presents stop; go to ACK.
- ACK: on the next fe (the 11th), sample synced data. Data=0 sets ack_ok=1, otherwise ack_ok=0. Then go to WAIT_IDLE.
- WAIT_IDLE: wait until synced clk=1 and dat=1 for 2 consecutive cycles. Then pulse o_done with the stored ack_ok and timeout=0, and return to IDLE.
- Timeout:
  - Active in SHIFT, ACK and WAIT_IDLE. The counter resets on every fe.
  - On reaching TIMEOUT_CYC: both OE=0, pulse o_done with o_timeout=1 and o_ack_ok=0, return to IDLE.
- OE ownership: both OE are 0 in IDLE and after done or timeout. The block never drives 1; the line floats high.
- o_ack_ok and o_timeout are held until the next accept, and qualified only at o_done.
- Simultaneous events:
  - fe together with timeout expiry: the fe wins and the counter clears.
  - i_valid in the same cycle as o_done: ignored, because o_ready rises the cycle after o_done.

Decomposition:
- Package ps2_pkg:
  - state enum: IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE;
  - command constants: CMD_SET_LED=8'hED, CMD_RESET=8'hFF, CMD_ECHO=8'hEE;
  - ACK_BYTE=8'hFA, for the receiver.
- Sub-module ps2_sync_edge: 2-FF synchronizer plus falling-edge detector for one line, instantiated for clk and dat. It is shared with the receiver path.

Test Plan:
- i_data=0xED, device model clocks at 12 kHz and acks. Required:
  - clk_oe low for ≥1300 cycles;
  - sampled bits 1,0,1,1,0,1,1,1 then parity 1 then stop 1;
  - o_done with o_ack_ok=1 and o_timeout=0.
- i_data=0x07: parity bit 0. i_data=0x00: parity bit 1. Device samples match in both cases, and ack_ok=1.
- 0xFF sent, device holds data high at the 11th fe → o_done with o_ack_ok=0 and o_timeout=0.
- 0xED sent, device stops clocking after 4 edges → o_done with o_timeout=1 exactly 24000 cycles after the last fe; both OE=0.
- i_rst=1 during bit 5 → next cycle both OE=0 and o_ready=1, no o_done. A new 0xEE then transfers with ack.
- A second i_valid pulse during SHIFT is ignored: exactly one o_done occurs and the byte received by the device equals the first byte.
